// File: rtl/instr_fetch_unit_if.sv
// Bus between the instruction fetch unit, the control FSM and the instruction ROM.
// The master side (the FSM plus the ROM) drives the strobes and rom_data; the fetch unit is the slave.
interface instr_fetch_unit_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic              en;
  logic              pc_load;
  logic              pc_inc;
  logic              ins_load;
  logic              jump_load;
  logic [ADDR_W-1:0] jump_addr;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_saved;
  logic [3:0]        opcode;
  logic [2:0]        op1_sel;
  logic [2:0]        op2_sel;
  logic [DATA_W-1:0] imm;
  logic              ir_valid;
  logic              two_byte;
  logic              imm_valid;

  modport master (
    output en, pc_load, pc_inc, ins_load, jump_load, jump_addr, rom_data,
    input  rom_addr, pc, pc_saved, opcode, op1_sel, op2_sel, imm,
           ir_valid, two_byte, imm_valid
  );

  modport slave (
    input  en, pc_load, pc_inc, ins_load, jump_load, jump_addr, rom_data,
    output rom_addr, pc, pc_saved, opcode, op1_sel, op2_sel, imm,
           ir_valid, two_byte, imm_valid
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: program counter, instruction register and the immediate word
// that follows the 2-byte opcodes MVI (4'b1100) and LDA (4'b1101).
module instr_fetch_unit #(
  parameter int              ADDR_W   = 8,
  parameter int              DATA_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic               clk,
  input logic               rst,
  instr_fetch_unit_if.slave bus
);

  typedef enum logic {FIRST, SECOND} word_state_t;

  word_state_t       state, state_nxt;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_saved_q;
  logic [9:0]        ir_q;          // IR[15:6]; the low six bits are never consumed
  logic [DATA_W-1:0] imm_q;
  logic              ir_valid_q;
  logic              two_byte_q;
  logic              imm_valid_q;

  logic              cap_ir;
  logic              cap_imm;
  logic              kill_imm;
  logic              is_two;

  assign is_two = (bus.rom_data[15:12] == 4'b1100) || (bus.rom_data[15:12] == 4'b1101);

  always_comb begin
    state_nxt = state;
    cap_ir    = 1'b0;
    cap_imm   = 1'b0;
    kill_imm  = 1'b0;
    if (bus.jump_load) begin
      // A jump abandons a pending second word and swallows a same-cycle ins_load.
      state_nxt = FIRST;
      kill_imm  = 1'b1;
    end else if (bus.ins_load) begin
      unique case (state)
        FIRST: begin
          cap_ir    = 1'b1;
          state_nxt = is_two ? SECOND : FIRST;
        end
        SECOND: begin
          cap_imm   = 1'b1;
          state_nxt = FIRST;
        end
        default: state_nxt = FIRST;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FIRST;
    end else if (bus.en) begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      pc_saved_q  <= '0;
      ir_q        <= '0;
      imm_q       <= '0;
      ir_valid_q  <= 1'b0;
      two_byte_q  <= 1'b0;
      imm_valid_q <= 1'b0;
    end else if (bus.en) begin
      if (bus.pc_load) pc_saved_q <= pc_q;
      if (bus.jump_load) pc_q <= bus.jump_addr;
      else if (bus.pc_inc) pc_q <= pc_q + ADDR_W'(1);
      if (cap_ir) begin
        ir_q        <= bus.rom_data[15:6];
        ir_valid_q  <= 1'b1;
        two_byte_q  <= is_two;
        imm_valid_q <= 1'b0;
      end
      if (cap_imm) begin
        imm_q       <= bus.rom_data;
        imm_valid_q <= 1'b1;
      end
      if (kill_imm) imm_valid_q <= 1'b0;
    end
  end

  assign bus.rom_addr  = pc_q;
  assign bus.pc        = pc_q;
  assign bus.pc_saved  = pc_saved_q;
  assign bus.opcode    = ir_q[9:6];
  assign bus.op1_sel   = ir_q[5:3];
  assign bus.op2_sel   = ir_q[2:0];
  assign bus.imm       = imm_q;
  assign bus.ir_valid  = ir_valid_q;
  assign bus.two_byte  = two_byte_q;
  assign bus.imm_valid = imm_valid_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed fetch sequences, then random strobes,
// all compared against an instruction-level reference model.
module tb_instr_fetch_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instr_fetch_unit_if #(.ADDR_W(8), .DATA_W(16)) bus ();

  instr_fetch_unit #(.ADDR_W(8), .DATA_W(16), .RESET_PC(8'h00)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [15:0] rom [256];
  assign bus.rom_data = rom[bus.rom_addr];

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // Reference model state: architectural view of the fetch unit.
  int unsigned m_pc, m_saved;
  logic [15:0] m_ir, m_imm;
  bit          m_irv, m_two, m_immv, m_want_imm;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic check_all();
    check("pc",        16'(bus.pc),        16'(m_pc));
    check("rom_addr",  16'(bus.rom_addr),  16'(m_pc));
    check("pc_saved",  16'(bus.pc_saved),  16'(m_saved));
    check("opcode",    16'(bus.opcode),    16'(m_ir[15:12]));
    check("op1_sel",   16'(bus.op1_sel),   16'(m_ir[11:9]));
    check("op2_sel",   16'(bus.op2_sel),   16'(m_ir[8:6]));
    check("imm",       bus.imm,            m_imm);
    check("ir_valid",  16'(bus.ir_valid),  16'(m_irv));
    check("two_byte",  16'(bus.two_byte),  16'(m_two));
    check("imm_valid", 16'(bus.imm_valid), 16'(m_immv));
  endtask

  task automatic model_step(input bit r, input bit e, input bit pl, input bit pi,
                            input bit il, input bit jl, input int unsigned ja);
    logic [15:0] word;
    word = rom[m_pc];
    if (r) begin
      m_pc = 0; m_saved = 0; m_ir = 0; m_imm = 0;
      m_irv = 0; m_two = 0; m_immv = 0; m_want_imm = 0;
    end else if (e) begin
      if (pl) m_saved = m_pc;
      if (jl) begin
        m_pc = ja;
        m_want_imm = 0;
        m_immv = 0;
      end else begin
        if (pi) m_pc = (m_pc + 1) % 256;
        if (il) begin
          if (m_want_imm) begin
            m_imm = word;
            m_immv = 1;
            m_want_imm = 0;
          end else begin
            m_ir = word;
            m_irv = 1;
            m_immv = 0;
            m_two = (word[15:12] == 4'hC) || (word[15:12] == 4'hD);
            m_want_imm = m_two;
          end
        end
      end
    end
  endtask

  task automatic cycle(input bit r, input bit e, input bit pl, input bit pi,
                       input bit il, input bit jl, input int unsigned ja);
    rst           = r;
    bus.en        = e;
    bus.pc_load   = pl;
    bus.pc_inc    = pi;
    bus.ins_load  = il;
    bus.jump_load = jl;
    bus.jump_addr = 8'(ja);
    model_step(r, e, pl, pi, il, jl, ja);
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 16'($urandom);
    rom[0] = 16'h0A40;
    rom[1] = 16'hC400;
    rom[2] = 16'h00FF;
    rom[4] = 16'hD123;
    rom[5] = 16'hBEEF;
    m_pc = 0; m_saved = 0; m_ir = 0; m_imm = 0;
    m_irv = 0; m_two = 0; m_immv = 0; m_want_imm = 0;

    // Reset with en low must still clear everything.
    cycle(1, 0, 0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0, 0);
    check("reset_pc_const", 16'(bus.pc), 16'h0000);

    // ADD r5,r1 then advance.
    cycle(0, 1, 1, 0, 1, 0, 0);
    cycle(0, 1, 0, 1, 0, 0, 0);
    check("add_op1_const", 16'(bus.op1_sel), 16'd5);
    check("add_op2_const", 16'(bus.op2_sel), 16'd1);

    // MVI r2, 0x00FF with capture and increment in the same cycle.
    cycle(0, 1, 0, 1, 1, 0, 0);
    cycle(0, 1, 0, 1, 1, 0, 0);
    check("mvi_imm_const", bus.imm, 16'h00FF);
    check("mvi_opcode_const", 16'(bus.opcode), 16'h000C);

    // PC wrap, then the same with en low.
    cycle(0, 1, 0, 0, 0, 1, 8'hFF);
    cycle(0, 1, 0, 1, 0, 0, 0);
    check("wrap_const", 16'(bus.pc), 16'h0000);
    cycle(0, 1, 0, 0, 0, 1, 8'hFF);
    cycle(0, 0, 1, 1, 1, 0, 0);
    check("hold_const", 16'(bus.pc), 16'h00FF);

    // Jump while waiting for the MVI immediate; ins_load in that cycle is dropped.
    cycle(0, 1, 0, 0, 0, 1, 8'h01);
    cycle(0, 1, 0, 1, 1, 0, 0);
    cycle(0, 1, 0, 0, 1, 1, 8'h40);
    check("jump_immv_const", 16'(bus.imm_valid), 16'h0000);

    // Reset mid 2-byte instruction (LDA at 4, pc=5) with en low.
    cycle(0, 1, 0, 0, 0, 1, 8'h04);
    cycle(0, 1, 0, 1, 1, 0, 0);
    check("lda_two_const", 16'(bus.two_byte), 16'h0001);
    cycle(1, 0, 0, 0, 0, 0, 0);

    // Random strobes.
    for (int n = 0; n < 400; n++) begin
      cycle(($urandom_range(0, 49) == 0),
            ($urandom_range(0, 7) != 0),
            1'($urandom),
            1'($urandom),
            ($urandom_range(0, 2) != 0),
            ($urandom_range(0, 9) == 0),
            $urandom_range(0, 255));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
